// File: rtl/ascon_ctrl_fsm.sv
// Control sequencer for the Ascon-128 permutation datapath: walks init, AD, PT and
// finalisation, issuing one permutation round per cycle with en_reg_state_o high.
module ascon_ctrl_fsm (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic       data_valid_i,
    input  logic       data_last_i,
    output logic       data_ready_o,
    output logic [3:0] round_o,
    output logic       data_sel_o,
    output logic       en_xor_data_o,
    output logic       en_xor_key_o,
    output logic       en_xor_key_end_o,
    output logic       en_xor_lsb_o,
    output logic       en_reg_state_o,
    output logic       cipher_valid_o,
    output logic       end_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        WAIT_AD = 3'd2,
        AD      = 3'd3,
        WAIT_PT = 3'd4,
        PT      = 3'd5,
        FINAL   = 3'd6,
        DONE    = 3'd7
    } state_t;

    localparam logic [3:0] RND_LAST  = 4'd11;
    localparam logic [3:0] RND_PB    = 4'd6;
    localparam logic [3:0] RND_PB_NX = 4'd7;

    state_t     state_q, state_d;
    logic [3:0] rnd_q, rnd_d;
    logic       last_q, last_d;

    // Round 11 is terminal; the counter saturates rather than wrapping.
    function automatic logic [3:0] next_round(input logic [3:0] r);
        logic [3:0] n;
        if (r == RND_LAST) begin
            n = RND_LAST;
        end else begin
            n = r + 4'd1;
        end
        return n;
    endfunction

    // State, round counter and last-block flag registers.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= IDLE;
            rnd_q   <= 4'd0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            last_q  <= last_d;
        end
    end

    // Next-state and control outputs; WAIT-state outputs follow data_valid_i directly.
    always_comb begin
        state_d          = state_q;
        rnd_d            = rnd_q;
        last_d           = last_q;
        data_ready_o     = 1'b0;
        round_o          = 4'd0;
        data_sel_o       = 1'b0;
        en_xor_data_o    = 1'b0;
        en_xor_key_o     = 1'b0;
        en_xor_key_end_o = 1'b0;
        en_xor_lsb_o     = 1'b0;
        en_reg_state_o   = 1'b0;
        cipher_valid_o   = 1'b0;
        end_o            = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    en_reg_state_o = 1'b1;
                    round_o        = 4'd0;
                    rnd_d          = 4'd1;
                    state_d        = INIT;
                end else begin
                    state_d = IDLE;
                end
            end

            INIT, FINAL: begin
                en_reg_state_o = 1'b1;
                data_sel_o     = 1'b1;
                round_o        = rnd_q;
                rnd_d          = next_round(rnd_q);
                if (rnd_q == RND_LAST) begin
                    en_xor_key_end_o = 1'b1;
                    state_d          = (state_q == INIT) ? WAIT_AD : DONE;
                end else begin
                    state_d = state_q;
                end
            end

            WAIT_AD: begin
                data_ready_o = 1'b1;
                round_o      = RND_PB;
                if (data_valid_i) begin
                    en_reg_state_o = 1'b1;
                    en_xor_data_o  = 1'b1;
                    data_sel_o     = 1'b1;
                    last_d         = data_last_i;
                    rnd_d          = RND_PB_NX;
                    state_d        = AD;
                end else begin
                    state_d = WAIT_AD;
                end
            end

            AD, PT: begin
                en_reg_state_o = 1'b1;
                data_sel_o     = 1'b1;
                round_o        = rnd_q;
                rnd_d          = next_round(rnd_q);
                if (rnd_q == RND_LAST) begin
                    if (state_q == AD) begin
                        en_xor_lsb_o = last_q;
                        state_d      = last_q ? WAIT_PT : WAIT_AD;
                    end else begin
                        state_d = WAIT_PT;
                    end
                end else begin
                    state_d = state_q;
                end
            end

            WAIT_PT: begin
                data_ready_o = 1'b1;
                // The last plaintext block starts finalisation as a full 12-round p^a.
                if (data_last_i) begin
                    round_o = 4'd0;
                end else begin
                    round_o = RND_PB;
                end
                if (data_valid_i) begin
                    en_reg_state_o = 1'b1;
                    en_xor_data_o  = 1'b1;
                    cipher_valid_o = 1'b1;
                    data_sel_o     = 1'b1;
                    en_xor_key_o   = data_last_i;
                    last_d         = data_last_i;
                    rnd_d          = data_last_i ? 4'd1 : RND_PB_NX;
                    state_d        = data_last_i ? FINAL : PT;
                end else begin
                    state_d = WAIT_PT;
                end
            end

            DONE: begin
                end_o   = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                rnd_d   = 4'd0;
                last_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Directed bench for ascon_ctrl_fsm: per-cycle expected control vectors, hand-derived.
module tb_ascon_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic       start = 1'b0;
    logic       dv = 1'b0;
    logic       dl = 1'b0;
    logic       data_ready, data_sel, xd, xk, xke, lsb, en, cv, endp;
    logic [3:0] round;
    logic [12:0] obs;
    logic [12:0] exp_v;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ascon_ctrl_fsm dut (
        .clock_i         (clk),
        .resetb_i        (rstb),
        .start_i         (start),
        .data_valid_i    (dv),
        .data_last_i     (dl),
        .data_ready_o    (data_ready),
        .round_o         (round),
        .data_sel_o      (data_sel),
        .en_xor_data_o   (xd),
        .en_xor_key_o    (xk),
        .en_xor_key_end_o(xke),
        .en_xor_lsb_o    (lsb),
        .en_reg_state_o  (en),
        .cipher_valid_o  (cv),
        .end_o           (endp)
    );

    assign obs = {data_ready, round, data_sel, xd, xk, xke, lsb, en, cv, endp};

    // Packs {ready, round, sel, xor_data, xor_key, xor_key_end, xor_lsb, en_reg, cipher_valid, end}.
    function automatic logic [12:0] ev(input logic rdy, input logic [3:0] r, input logic sel,
                                       input logic x_d, input logic x_k, input logic x_ke,
                                       input logic x_l, input logic e_r, input logic c_v,
                                       input logic e_o);
        return {rdy, r, sel, x_d, x_k, x_ke, x_l, e_r, c_v, e_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_init();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        repeat (2) tick();
        #1;
        checks++;
        if (obs !== 13'd0) begin errors++; $display("FAIL reset_hold: got %b exp %b", obs, 13'd0); end
        rstb = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2 rstb = 1'b0;
        #1;
        checks++;
        if (obs !== 13'd0) begin errors++; $display("FAIL reset_async: got %b exp %b", obs, 13'd0); end
        #2 rstb = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (obs !== 13'd0) begin errors++; $display("FAIL reset_idle c%0d: got %b exp %b", i, obs, 13'd0); end
            tick();
        end
    endtask

    task automatic test_init();
        start = 1'b1;
        #1;
        exp_v = ev(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL init r0: got %b exp %b", obs, exp_v); end
        tick();
        start = 1'b0;
        for (int r = 1; r <= 11; r++) begin
            #1;
            exp_v = ev(1'b0, 4'(r), 1'b1, 1'b0, 1'b0, (r == 11), 1'b0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL init r%0d: got %b exp %b", r, obs, exp_v); end
            tick();
        end
        #1;
        exp_v = ev(1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL init wait_ad: got %b exp %b", obs, exp_v); end
    endtask

    task automatic test_ad_blocks();
        for (int b = 0; b < 2; b++) begin
            dv = 1'b1;
            dl = (b == 1);
            #1;
            exp_v = ev(1'b1, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL ad%0d hs: got %b exp %b", b, obs, exp_v); end
            tick();
            dv = 1'b0;
            dl = 1'b0;
            for (int r = 7; r <= 11; r++) begin
                #1;
                exp_v = ev(1'b0, 4'(r), 1'b1, 1'b0, 1'b0, 1'b0, (b == 1 && r == 11), 1'b1, 1'b0, 1'b0);
                checks++;
                if (obs !== exp_v) begin errors++; $display("FAIL ad%0d r%0d: got %b exp %b", b, r, obs, exp_v); end
                tick();
            end
        end
        #1;
        exp_v = ev(1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL ad wait_pt: got %b exp %b", obs, exp_v); end
    endtask

    task automatic test_pt_blocks();
        dv = 1'b1;
        dl = 1'b0;
        #1;
        exp_v = ev(1'b1, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL pt hs: got %b exp %b", obs, exp_v); end
        tick();
        dv = 1'b0;
        for (int r = 7; r <= 11; r++) begin
            #1;
            exp_v = ev(1'b0, 4'(r), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL pt r%0d: got %b exp %b", r, obs, exp_v); end
            tick();
        end
        dv = 1'b1;
        dl = 1'b1;
        #1;
        exp_v = ev(1'b1, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL pt last hs: got %b exp %b", obs, exp_v); end
        tick();
        dv = 1'b0;
        dl = 1'b0;
        for (int r = 1; r <= 11; r++) begin
            #1;
            exp_v = ev(1'b0, 4'(r), 1'b1, 1'b0, 1'b0, (r == 11), 1'b0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL final r%0d: got %b exp %b", r, obs, exp_v); end
            tick();
        end
        #1;
        exp_v = ev(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL done: got %b exp %b", obs, exp_v); end
        tick();
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (obs !== 13'd0) begin errors++; $display("FAIL post_done c%0d: got %b exp %b", i, obs, 13'd0); end
            tick();
        end
    endtask

    task automatic test_stall();
        drive_init();
        dv = 1'b1;
        dl = 1'b1;
        tick();
        dv = 1'b0;
        dl = 1'b0;
        tick();
        start = 1'b1;
        #1;
        exp_v = ev(1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL start_in_ad: got %b exp %b", obs, exp_v); end
        tick();
        start = 1'b0;
        for (int r = 9; r <= 11; r++) begin
            #1;
            exp_v = ev(1'b0, 4'(r), 1'b1, 1'b0, 1'b0, 1'b0, (r == 11), 1'b1, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL stall ad r%0d: got %b exp %b", r, obs, exp_v); end
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            #1;
            exp_v = ev(1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_v) begin errors++; $display("FAIL stall c%0d: got %b exp %b", i, obs, exp_v); end
            tick();
        end
        test_pt_blocks();
    endtask

    task automatic test_latency();
        dv = 1'b1;
        dl = 1'b1;
        start = 1'b1;
        for (int n = 0; n < 33; n++) begin
            #1;
            checks++;
            if (endp !== (n == 30)) begin errors++; $display("FAIL latency n%0d: end_o got %b exp %b", n, endp, (n == 30)); end
            tick();
            start = 1'b0;
        end
        dv = 1'b0;
        dl = 1'b0;
    endtask

    task automatic test_reset_in_final();
        drive_init();
        dv = 1'b1;
        dl = 1'b1;
        tick();
        dv = 1'b0;
        dl = 1'b0;
        repeat (5) tick();
        dv = 1'b1;
        dl = 1'b1;
        tick();
        dv = 1'b0;
        dl = 1'b0;
        repeat (4) tick();
        #1;
        exp_v = ev(1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL final r5 pre_reset: got %b exp %b", obs, exp_v); end
        #1 rstb = 1'b0;
        #1;
        checks++;
        if (obs !== 13'd0) begin errors++; $display("FAIL reset_in_final: got %b exp %b", obs, 13'd0); end
        #1 rstb = 1'b1;
        tick();
        test_init();
    endtask

    initial begin
        test_reset();
        tick();
        test_init();
        test_ad_blocks();
        test_pt_blocks();
        test_stall();
        test_latency();
        test_reset_in_final();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
